// File: rtl/cpu_control.sv
// cpu_control: instruction sequencer for the 8-bit CPU.
// Fetches from a 16-byte memory, decodes, drives the external ALU and
// owns pc, accumulator A, operand B, IR, zero flag and an output port.
//
// Output handshake: out_valid/out_ready follow strict valid/ready rules.
// Once out_valid rises it stays high with out_data held stable until a
// rising clock edge samples out_ready high; that edge is the transfer.
// out_ready seen while out_valid is low has no effect.
module cpu_control #(
  parameter logic [1:0] ALU_ADD = 2'd0,
  parameter logic [1:0] ALU_SUB = 2'd1,
  parameter logic [1:0] ALU_AND = 2'd2,
  parameter logic [1:0] ALU_OR  = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_rdata,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  output logic       alu_en,
  output logic [1:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       halted,
  output logic [3:0] pc
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_STA = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_LOADA,
    S_LOADB,
    S_EXEC,
    S_WB,
    S_MEMWR,
    S_OUTPUT,
    S_HALT
  } state_t;

  state_t     state;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] ir;
  logic       z;

  logic [3:0] dec_op;
  logic [3:0] dec_n;
  logic [3:0] pc_inc;
  logic [3:0] dec_pc;

  // Decode helpers: the instruction is consumed straight off mem_rdata in
  // DECODE, so the next pc (including taken jumps) is known that cycle.
  assign dec_op = mem_rdata[7:4];
  assign dec_n  = mem_rdata[3:0];
  assign pc_inc = pc + 4'd1;
  assign dec_pc = ((dec_op == OP_JMP) || ((dec_op == OP_JZ) && z)) ? dec_n : pc_inc;

  // ALU operands follow the registers continuously; only alu_en qualifies them.
  assign alu_a = a;
  assign alu_b = b;

  // Map the stored opcode onto the ALU operation encoding.
  always_comb begin
    alu_op = ALU_ADD;
    case (ir[7:4])
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      default: alu_op = ALU_ADD;
    endcase
  end

  // Sequencer: outputs are registered together with the state they belong
  // to, so every transition also loads the strobes of the state it enters.
  // Coming out of reset the FSM sits in FETCH with mem_rd low; that first
  // cycle only arms the fetch strobe, after which FETCH always has mem_rd high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= 4'd0;
      a         <= 8'h00;
      b         <= 8'h00;
      ir        <= 8'h00;
      z         <= 1'b1;
      mem_addr  <= 4'd0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= 8'h00;
      alu_en    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      halted    <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      alu_en <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!mem_rd) begin
            mem_rd   <= 1'b1;
            mem_addr <= pc;
          end else begin
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          ir <= mem_rdata;
          pc <= dec_pc;
          case (dec_op)
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              state    <= S_MEMRD;
              mem_rd   <= 1'b1;
              mem_addr <= dec_n;
            end
            OP_STA: begin
              state     <= S_MEMWR;
              mem_wr    <= 1'b1;
              mem_addr  <= dec_n;
              mem_wdata <= a;
            end
            OP_OUT: begin
              state     <= S_OUTPUT;
              out_valid <= 1'b1;
              out_data  <= a;
            end
            OP_HLT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            OP_LDI: begin
              a        <= {4'h0, dec_n};
              z        <= (dec_n == 4'h0);
              state    <= S_FETCH;
              mem_rd   <= 1'b1;
              mem_addr <= dec_pc;
            end
            default: begin
              // JMP, JZ and NOPs: only the pc moves.
              state    <= S_FETCH;
              mem_rd   <= 1'b1;
              mem_addr <= dec_pc;
            end
          endcase
        end

        S_MEMRD: begin
          mem_addr <= ir[3:0];
          state    <= (ir[7:4] == OP_LDA) ? S_LOADA : S_LOADB;
        end

        S_LOADA: begin
          a        <= mem_rdata;
          z        <= (mem_rdata == 8'h00);
          state    <= S_FETCH;
          mem_rd   <= 1'b1;
          mem_addr <= pc;
        end

        S_LOADB: begin
          b      <= mem_rdata;
          state  <= S_EXEC;
          alu_en <= 1'b1;
        end

        S_EXEC: begin
          state <= S_WB;
        end

        S_WB: begin
          a        <= alu_out;
          z        <= (alu_out == 8'h00);
          state    <= S_FETCH;
          mem_rd   <= 1'b1;
          mem_addr <= pc;
        end

        S_MEMWR: begin
          state    <= S_FETCH;
          mem_rd   <= 1'b1;
          mem_addr <= pc;
        end

        S_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_FETCH;
            mem_rd    <= 1'b1;
            mem_addr  <= pc;
          end
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: behavioural 16-byte memory and ALU,
// a posedge monitor logging bus activity, and checks at the falling edge.
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic       alu_en;
  logic [1:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out = 8'h00;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       halted;
  logic [3:0] pc;

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  cpu_control dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .alu_en    (alu_en),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .halted    (halted),
    .pc        (pc)
  );

  // Program image and load request, written only by the stimulus block.
  logic [7:0] img [16];
  logic       load = 1'b0;
  logic [7:0] mem [16];

  // Memory model: image load, synchronous write, read data one cycle later.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= img[i];
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // ALU model: registered result on alu_en.
  always @(posedge clk) begin
    if (alu_en) begin
      case (alu_op)
        2'd0: alu_out <= alu_a + alu_b;
        2'd1: alu_out <= alu_a - alu_b;
        2'd2: alu_out <= alu_a & alu_b;
        default: alu_out <= alu_a | alu_b;
      endcase
    end
  end

  // Bus monitor: logs what the DUT presents at each rising edge.
  int          cyc = 0;
  logic [3:0]  rd_addr_q [$];
  int          rd_cyc_q  [$];
  logic [11:0] wr_q      [$];
  logic [7:0]  xfer_q    [$];
  int          alu_cnt = 0;
  logic [17:0] alu_last = '0;
  int          valid_cyc = 0;
  int          unstable = 0;
  logic        valid_prev = 1'b0;
  logic [7:0]  data_prev = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (mem_rd) begin
      rd_addr_q.push_back(mem_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (mem_wr) wr_q.push_back({mem_addr, mem_wdata});
    if (alu_en) begin
      alu_cnt++;
      alu_last = {alu_op, alu_a, alu_b};
    end
    if (out_valid) begin
      valid_cyc++;
      if (valid_prev && (out_data !== data_prev)) unstable++;
    end
    if (out_valid && out_ready) xfer_q.push_back(out_data);
    valid_prev = out_valid;
    data_prev  = out_data;
  end

  // Scoreboard state.
  logic [7:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;
  int rbase, abase, xbase, wbase, vbase, ubase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  // Assert reset, load the image, then release with the given out_ready.
  task automatic start_prog(input logic ready);
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = ready;
    rbase = rd_addr_q.size();
    abase = alu_cnt;
    xbase = xfer_q.size();
    wbase = wr_q.size();
    vbase = valid_cyc;
    ubase = unstable;
    rst   = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string tag);
    int k;
    k = 0;
    while ((halted !== 1'b1) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(halted), 32'd1);
  endtask

  // Compare transfers since xbase against the expected queue.
  task automatic check_xfers(input string tag);
    chk({tag, "_count"}, 32'(xfer_q.size() - xbase), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (xbase + i) < xfer_q.size(); i++)
      chk({tag, "_data"}, 32'(xfer_q[xbase + i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  // Stop runaway simulations.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_addr [6];
    int         exp_gap  [5];
    int         k;

    // ---- Reset + program 1: LDA 14, ADD 15, OUT, HLT ----
    clear_img();
    img[0] = 8'h0E; img[1] = 8'h1F; img[2] = 8'hE0; img[3] = 8'hF0;
    img[14] = 8'hF0; img[15] = 8'h20;
    rst = 1'b1;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
    end
    chk("rst_strobes", 32'({mem_rd, mem_wr, alu_en, out_valid, halted}), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_z_a", 32'({dut.z, dut.a}), 32'h100);
    out_ready = 1'b1;
    rbase = rd_addr_q.size(); abase = alu_cnt; xbase = xfer_q.size();
    rst = 1'b0;
    @(negedge clk);
    chk("first_fetch", 32'({mem_rd, mem_addr}), 32'h10);
    wait_halt(60, "p1_halt");
    chk("p1_pc", 32'(pc), 32'd4);
    chk("p1_z", 32'(dut.z), 32'd0);
    chk("p1_alu_pulses", 32'(alu_cnt - abase), 32'd1);
    chk("p1_alu_args", 32'(alu_last), 32'({2'd0, 8'hF0, 8'h20}));
    exp_q.push_back(8'h10);
    check_xfers("p1_out");
    // Read sequence and spacing: LDA takes 4 cycles, ADD 6, OUT 3.
    exp_addr = '{4'd0, 4'd14, 4'd1, 4'd15, 4'd2, 4'd3};
    exp_gap  = '{2, 2, 2, 4, 3};
    chk("p1_rd_count", 32'(rd_addr_q.size() - rbase), 32'd6);
    for (int i = 0; i < 6 && (rbase + i) < rd_addr_q.size(); i++)
      chk("p1_rd_addr", 32'(rd_addr_q[rbase + i]), 32'(exp_addr[i]));
    for (int i = 0; i < 5 && (rbase + i + 1) < rd_cyc_q.size(); i++)
      chk("p1_rd_gap", 32'(rd_cyc_q[rbase + i + 1] - rd_cyc_q[rbase + i]), 32'(exp_gap[i]));
    // HALT is terminal regardless of out_ready.
    repeat (4) begin
      @(negedge clk);
      out_ready = ~out_ready;
    end
    @(negedge clk);
    chk("halt_frozen", 32'({halted, out_valid, mem_rd, mem_wr, alu_en, pc}), 32'({5'b10000, 4'd4}));
    chk("halt_no_xfer", 32'(xfer_q.size() - xbase), 32'd1);

    // ---- Program 2: LDI 3, SUB 15, JZ 5, OUT, HLT, LDI 9, OUT, HLT ----
    clear_img();
    img[0] = 8'h63; img[1] = 8'h2F; img[2] = 8'h85; img[3] = 8'hE0;
    img[4] = 8'hF0; img[5] = 8'h69; img[6] = 8'hE0; img[7] = 8'hF0;
    img[15] = 8'h03;
    start_prog(1'b1);
    k = 0;
    while ((alu_en !== 1'b1) && (k < 40)) begin
      @(negedge clk);
      k++;
    end
    chk("p2_exec_seen", 32'(alu_en), 32'd1);
    repeat (2) @(negedge clk);
    chk("p2_z_after_sub", 32'({dut.z, dut.a}), 32'h100);
    wait_halt(60, "p2_halt");
    chk("p2_pc", 32'(pc), 32'd8);
    chk("p2_alu_args", 32'(alu_last), 32'({2'd1, 8'h03, 8'h03}));
    exp_q.push_back(8'h09);
    check_xfers("p2_out");

    // ---- Program 3: output backpressure, LDI 5, OUT, HLT ----
    clear_img();
    img[0] = 8'h65; img[1] = 8'hE0; img[2] = 8'hF0;
    start_prog(1'b0);
    k = 0;
    while ((out_valid !== 1'b1) && (k < 40)) begin
      @(negedge clk);
      k++;
    end
    chk("p3_valid_seen", 32'({out_valid, out_data}), 32'h105);
    repeat (5) begin
      @(negedge clk);
      chk("p3_valid_held", 32'({out_valid, out_data}), 32'h105);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("p3_valid_drop", 32'(out_valid), 32'd0);
    chk("p3_valid_cycles", 32'(valid_cyc - vbase), 32'd6);
    chk("p3_stable", 32'(unstable - ubase), 32'd0);
    exp_q.push_back(8'h05);
    check_xfers("p3_out");
    wait_halt(20, "p3_halt");
    chk("p3_pc", 32'(pc), 32'd3);

    // ---- Program 4: STA 13 at 0, JZ 15, HLT; LDI 7 at 15 wraps to 0 ----
    clear_img();
    img[0] = 8'h5D; img[1] = 8'h8F; img[2] = 8'hF0; img[15] = 8'h67;
    start_prog(1'b1);
    wait_halt(60, "p4_halt");
    chk("p4_pc", 32'(pc), 32'd3);
    chk("p4_wr_count", 32'(wr_q.size() - wbase), 32'd2);
    if (wr_q.size() - wbase >= 2) begin
      chk("p4_wr0", 32'(wr_q[wbase]), 32'h D00);
      chk("p4_wr1", 32'(wr_q[wbase + 1]), 32'h D07);
    end
    chk("p4_mem13", 32'(mem[13]), 32'h07);
    exp_addr = '{4'd0, 4'd1, 4'd15, 4'd0, 4'd1, 4'd2};
    chk("p4_rd_count", 32'(rd_addr_q.size() - rbase), 32'd6);
    for (int i = 0; i < 6 && (rbase + i) < rd_addr_q.size(); i++)
      chk("p4_rd_addr", 32'(rd_addr_q[rbase + i]), 32'(exp_addr[i]));

    // ---- Program 5: AND/OR, LDI 12, AND 14, OR 15, OUT, HLT ----
    clear_img();
    img[0] = 8'h6C; img[1] = 8'h3E; img[2] = 8'h4F; img[3] = 8'hE0; img[4] = 8'hF0;
    img[14] = 8'h0A; img[15] = 8'h30;
    start_prog(1'b1);
    wait_halt(80, "p5_halt");
    chk("p5_alu_pulses", 32'(alu_cnt - abase), 32'd2);
    chk("p5_alu_args", 32'(alu_last), 32'({2'd3, 8'h08, 8'h30}));
    exp_q.push_back(8'h38);
    check_xfers("p5_out");

    // ---- Program 6: reset during EXEC of ADD; LDI 5, ADD 15, OUT, HLT ----
    clear_img();
    img[0] = 8'h65; img[1] = 8'h1F; img[2] = 8'hE0; img[3] = 8'hF0; img[15] = 8'h01;
    start_prog(1'b1);
    k = 0;
    while ((alu_en !== 1'b1) && (k < 40)) begin
      @(negedge clk);
      k++;
    end
    chk("p6_exec_seen", 32'(alu_en), 32'd1);
    rst = 1'b1;
    abase = alu_cnt;
    repeat (3) @(negedge clk);
    chk("p6_rst_strobes", 32'({mem_rd, mem_wr, alu_en, out_valid}), 32'd0);
    chk("p6_rst_state", 32'({pc, dut.a}), 32'd0);
    chk("p6_no_alu", 32'(alu_cnt - abase), 32'd0);
    rbase = rd_addr_q.size();
    xbase = xfer_q.size();
    rst = 1'b0;
    @(negedge clk);
    chk("p6_first_fetch", 32'({mem_rd, mem_addr}), 32'h10);
    wait_halt(60, "p6_halt");
    chk("p6_pc", 32'(pc), 32'd4);
    chk("p6_alu_pulses", 32'(alu_cnt - abase), 32'd1);
    chk("p6_rd0", 32'(rd_addr_q[rbase]), 32'd0);
    exp_q.push_back(8'h06);
    check_xfers("p6_out");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
